mem_access_stage: RTL and testbench
===================================

MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on posedge clk.
REQ-002 SHALL have port rst, input, 1 bit: asynchronous, active-low reset; the block is in reset while rst=0.
REQ-003 SHALL have EX/MEM register inputs:
- valid_i, input, 1: slot holds a live instruction.
- wmemi, input, 1: store.
- rmemi, input, 1: load.
- wregi, input, 1: register writeback requested.
- jmpi, input, 1: jump marker.
- ALURi, input, 32: ALU result / effective address.
- StDatai, input, 32: store data.
- WrDesti, input, 4: destination register.
REQ-004 SHALL have data-memory ports:
- mem_req, output, 1.
- mem_we, output, 1.
- mem_addr, output, 32.
- mem_wdata, output, 32.
- mem_rdata, input, 32.
- mem_ack, input, 1: one-cycle completion pulse.
REQ-005 SHALL have MEM/WB outputs:
- wb_valid, output, 1.
- wb_data, output, 32.
- wb_dest, output, 4.
- wb_wreg, output, 1.
- wb_jmp, output, 1.
REQ-006 SHALL have status outputs:
- stall, output, 1: freeze upstream stages.
- err, output, 1: sticky error flag.

Function
REQ-007 SHALL implement FSM with states IDLE and WAIT.
REQ-008 In IDLE with valid_i=1 and rmemi=wmemi=0, SHALL register the MEM/WB outputs at the next edge (1-cycle latency) with no memory request:
- wb_data=ALURi, wb_dest=WrDesti, wb_wreg=wregi, wb_jmp=jmpi, wb_valid=1.
REQ-009 In IDLE with valid_i=1 and (rmemi|wmemi)=1 and ALURi[1:0]=00, SHALL assert mem_req combinationally in that cycle and enter WAIT at the next edge.
- mem_addr=ALURi, mem_wdata=StDatai, mem_we=wmemi.
REQ-010 If rmemi and wmemi are both 1, the access SHALL be a write (mem_we=1) with no read data captured.
REQ-011 In WAIT, mem_req, mem_we, mem_addr and mem_wdata SHALL be held from internal registers, stable until mem_ack.
REQ-012 stall SHALL be high in the IDLE cycle that issues a request, and in every WAIT cycle where mem_ack=0; stall SHALL be low otherwise.
REQ-013 When mem_ack=1 in WAIT, the block SHALL return to IDLE at the next edge and register the MEM/WB outputs:
- wb_valid=1, wb_dest=latched WrDesti, wb_wreg=latched wregi, wb_jmp=latched jmpi.
- wb_data=mem_rdata for a load, latched ALURi for a store.
REQ-014 A store SHALL always produce wb_wreg=0, regardless of wregi.
REQ-015 mem_ack received in IDLE SHALL be ignored.
REQ-016 A misaligned access (ALURi[1:0]!=00 with rmemi|wmemi) SHALL:
- issue no request and cause no stall;
- produce wb_valid=1 with wb_wreg=0 at the next edge;
- set err.
REQ-017 wb_valid SHALL be low in any cycle that does not complete an instruction (IDLE with valid_i=0, or WAIT without ack).
REQ-018 err SHALL stay set until reset.
REQ-019 Inputs SHALL NOT be sampled in WAIT; upstream holds them under stall.

Reset
REQ-020 While rst=0, the block SHALL be forced to the following values, immediately and regardless of clk:
- state=IDLE, mem_req=0, mem_we=0.
- mem_addr=0, mem_wdata=0.
- wb_valid=0, wb_data=0, wb_dest=0, wb_wreg=0, wb_jmp=0.
- stall=0, err=0.
REQ-021 Reset during WAIT SHALL abandon the access; a later mem_ack SHALL have no effect.
REQ-022 On rst release, the first live instruction SHALL be accepted at the first posedge.

Configuration
REQ-023 When macro MEM_STAGE_TIMEOUT_EN is defined, the block SHALL include a 4-bit wait counter that clears on entering WAIT.
- If mem_ack is still absent after 15 WAIT cycles, the block SHALL drop mem_req, return to IDLE and set err.
- It SHALL produce wb_valid=1 with wb_wreg=0 at that edge.
REQ-024 When MEM_STAGE_TIMEOUT_EN is undefined, there SHALL be no counter, and WAIT SHALL persist indefinitely until mem_ack.

Verification
REQ-025 ALU op, ALURi=0x0000_0010, WrDesti=3, wregi=1 -> next cycle wb_valid=1, wb_data=0x10, wb_dest=3, stall never high.
REQ-026 Load at ALURi=0x100, mem_ack on 3rd WAIT cycle with mem_rdata=0xDEADBEEF:
- mem_req held 4 cycles, address constant, stall high 3 cycles;
- then wb_data=0xDEADBEEF, wb_wreg=1.
REQ-027 Store with wmemi=rmemi=1, ALURi=0x200, StDatai=0x55, wregi=1, immediate ack:
- mem_we=1, mem_wdata=0x55;
- then wb_wreg=0.
REQ-028 Load at ALURi=0x103 -> mem_req never asserted, err=1, wb_valid=1, wb_wreg=0.
REQ-029 rst pulled low in the 2nd WAIT cycle, ack arriving afterwards -> all outputs 0, state IDLE, no wb_valid pulse.
REQ-030 With MEM_STAGE_TIMEOUT_EN defined and no ack -> mem_req drops after 15 WAIT cycles, err=1, wb_wreg=0; without the macro, mem_req still high after 100 cycles.

Source files
------------

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: passes ALU results through, runs one aligned load/store at a time.
// Optional MEM_STAGE_TIMEOUT_EN gives up on an access after 15 unanswered WAIT cycles.
module mem_access_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  input  logic        wmemi,
  input  logic        rmemi,
  input  logic        wregi,
  input  logic        jmpi,
  input  logic [31:0] ALURi,
  input  logic [31:0] StDatai,
  input  logic [3:0]  WrDesti,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        wb_valid,
  output logic [31:0] wb_data,
  output logic [3:0]  wb_dest,
  output logic        wb_wreg,
  output logic        wb_jmp,
  output logic        stall,
  output logic        err
);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t      r_state;
  logic        r_memWe;
  logic [31:0] r_memAddr;
  logic [31:0] r_memWdata;
  logic        r_isLoad;
  logic [3:0]  r_dest;
  logic        r_wreg;
  logic        r_jmp;
`ifdef MEM_STAGE_TIMEOUT_EN
  logic [3:0]  r_cnt;
`endif

  logic w_inWait;
  logic w_isMem;
  logic w_aligned;
  logic w_issue;

  // Gating with rst keeps the combinational request quiet while reset is held.
  assign w_inWait  = (r_state == WAIT);
  assign w_isMem   = valid_i & (rmemi | wmemi);
  assign w_aligned = (ALURi[1:0] == 2'b00);
  assign w_issue   = rst & (r_state == IDLE) & w_isMem & w_aligned;

  assign mem_req   = w_issue | w_inWait;
  assign mem_we    = w_inWait ? r_memWe    : (w_issue & wmemi);
  assign mem_addr  = w_inWait ? r_memAddr  : (w_issue ? ALURi   : 32'h0);
  assign mem_wdata = w_inWait ? r_memWdata : (w_issue ? StDatai : 32'h0);
  assign stall     = w_issue | (w_inWait & ~mem_ack);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_memWe    <= 1'b0;
      r_memAddr  <= 32'h0;
      r_memWdata <= 32'h0;
      r_isLoad   <= 1'b0;
      r_dest     <= 4'h0;
      r_wreg     <= 1'b0;
      r_jmp      <= 1'b0;
`ifdef MEM_STAGE_TIMEOUT_EN
      r_cnt      <= 4'h0;
`endif
      wb_valid   <= 1'b0;
      wb_data    <= 32'h0;
      wb_dest    <= 4'h0;
      wb_wreg    <= 1'b0;
      wb_jmp     <= 1'b0;
      err        <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (valid_i) begin
            if (!w_isMem) begin
              wb_valid <= 1'b1;
              wb_data  <= ALURi;
              wb_dest  <= WrDesti;
              wb_wreg  <= wregi;
              wb_jmp   <= jmpi;
            end else if (!w_aligned) begin
              // Misaligned access retires without touching memory or the register file.
              wb_valid <= 1'b1;
              wb_data  <= ALURi;
              wb_dest  <= WrDesti;
              wb_wreg  <= 1'b0;
              wb_jmp   <= jmpi;
              err      <= 1'b1;
            end else begin
              r_state    <= WAIT;
              r_memWe    <= wmemi;
              r_memAddr  <= ALURi;
              r_memWdata <= StDatai;
              r_isLoad   <= rmemi & ~wmemi;
              r_dest     <= WrDesti;
              r_wreg     <= wregi & ~wmemi;
              r_jmp      <= jmpi;
`ifdef MEM_STAGE_TIMEOUT_EN
              r_cnt      <= 4'h0;
`endif
            end
          end
        end
        WAIT: begin
          if (mem_ack) begin
            r_state  <= IDLE;
            wb_valid <= 1'b1;
            wb_data  <= r_isLoad ? mem_rdata : r_memAddr;
            wb_dest  <= r_dest;
            wb_wreg  <= r_wreg;
            wb_jmp   <= r_jmp;
          end
`ifdef MEM_STAGE_TIMEOUT_EN
          // Count 14 marks the 15th unanswered WAIT cycle.
          else if (r_cnt == 4'd14) begin
            r_state  <= IDLE;
            wb_valid <= 1'b1;
            wb_data  <= r_memAddr;
            wb_dest  <= r_dest;
            wb_wreg  <= 1'b0;
            wb_jmp   <= r_jmp;
            err      <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
`endif
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed self-checking bench for mem_access_stage.
// Follows MEM_STAGE_TIMEOUT_EN to pick the expected no-ack behaviour.
module tb_mem_access_stage;

  logic        clk;
  logic        rst;
  logic        valid_i, wmemi, rmemi, wregi, jmpi;
  logic [31:0] ALURi, StDatai;
  logic [3:0]  WrDesti;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ack;
  logic        wb_valid;
  logic [31:0] wb_data;
  logic [3:0]  wb_dest;
  logic        wb_wreg, wb_jmp, stall, err;

  int checkCount = 0;
  int errorCount = 0;

  mem_access_stage dut (
    .clk(clk), .rst(rst),
    .valid_i(valid_i), .wmemi(wmemi), .rmemi(rmemi), .wregi(wregi), .jmpi(jmpi),
    .ALURi(ALURi), .StDatai(StDatai), .WrDesti(WrDesti),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .wb_valid(wb_valid), .wb_data(wb_data), .wb_dest(wb_dest), .wb_wreg(wb_wreg),
    .wb_jmp(wb_jmp), .stall(stall), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case a scenario loses track of time.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input logic v, input logic wm, input logic rm, input logic wr,
                               input logic j, input logic [31:0] alu, input logic [31:0] st,
                               input logic [3:0] d);
    valid_i = v; wmemi = wm; rmemi = rm; wregi = wr; jmpi = j;
    ALURi = alu; StDatai = st; WrDesti = d;
  endtask

  task automatic driveIdle();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  // Reset held with a live aligned load on the inputs: everything must read zero.
  task automatic test_reset();
    rst = 1'b0; mem_ack = 1'b0; mem_rdata = 32'h0;
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h100, 32'h77, 4'd4);
    #3;
    checkCount++;
    if ({mem_req, mem_we, stall, err, wb_valid, wb_wreg, wb_jmp} !== 7'b0) begin
      errorCount++;
      $display("[TB] FAIL reset_flags: got %b expected 0000000",
               {mem_req, mem_we, stall, err, wb_valid, wb_wreg, wb_jmp});
    end
    checkCount++;
    if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
      errorCount++;
      $display("[TB] FAIL reset_mem_bus: got addr %h wdata %h expected 0", mem_addr, mem_wdata);
    end
    checkCount++;
    if (wb_data !== 32'h0 || wb_dest !== 4'h0) begin
      errorCount++;
      $display("[TB] FAIL reset_wb: got data %h dest %h expected 0", wb_data, wb_dest);
    end
    @(posedge clk); #1;
    checkCount++;
    if (mem_req !== 1'b0 || wb_valid !== 1'b0) begin
      errorCount++;
      $display("[TB] FAIL reset_after_edge: got req %b wbv %b expected 0 0", mem_req, wb_valid);
    end
  endtask

  // Release reset and present an ALU op immediately; it must retire at the first edge.
  task automatic test_alu();
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 4'd3);
    #1;
    checkCount++;
    if (stall !== 1'b0 || mem_req !== 1'b0) begin
      errorCount++;
      $display("[TB] FAIL alu_no_req: got stall %b req %b expected 0 0", stall, mem_req);
    end
    @(posedge clk); #1;
    driveIdle();
    checkCount++;
    if (wb_valid !== 1'b1 || wb_data !== 32'h10 || wb_dest !== 4'd3 || wb_wreg !== 1'b1 || stall !== 1'b0) begin
      errorCount++;
      $display("[TB] FAIL alu_wb: got v%b d%h r%h w%b s%b expected v1 d00000010 r3 w1 s0",
               wb_valid, wb_data, wb_dest, wb_wreg, stall);
    end
    @(posedge clk); #1;
    checkCount++;
    if (wb_valid !== 1'b0) begin
      errorCount++;
      $display("[TB] FAIL alu_bubble: got wb_valid %b expected 0", wb_valid);
    end
  endtask

  // Load answered on the third WAIT cycle; inputs are scrambled while waiting.
  task automatic test_load();
    mem_ack = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h100, 32'h0, 4'd5);
    #1;
    checkCount++;
    if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h100 || stall !== 1'b1) begin
      errorCount++;
      $display("[TB] FAIL load_issue: got req%b we%b a%h s%b expected req1 we0 a00000100 s1",
               mem_req, mem_we, mem_addr, stall);
    end
    for (int i = 1; i <= 2; i++) begin
      @(posedge clk); #1;
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'hFFF0, 32'hAAAA, 4'd9);
      #1;
      checkCount++;
      if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h100 || stall !== 1'b1 || wb_valid !== 1'b0) begin
        errorCount++;
        $display("[TB] FAIL load_wait%0d: got req%b we%b a%h s%b v%b expected req1 we0 a00000100 s1 v0",
                 i, mem_req, mem_we, mem_addr, stall, wb_valid);
      end
    end
    @(posedge clk); #1;
    mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
    #1;
    checkCount++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h100 || stall !== 1'b0) begin
      errorCount++;
      $display("[TB] FAIL load_ack_cycle: got req%b a%h s%b expected req1 a00000100 s0",
               mem_req, mem_addr, stall);
    end
    @(posedge clk); #1;
    mem_ack = 1'b0;
    driveIdle();
    checkCount++;
    if (wb_valid !== 1'b1 || wb_data !== 32'hDEADBEEF || wb_wreg !== 1'b1 || wb_dest !== 4'd5 || mem_req !== 1'b0) begin
      errorCount++;
      $display("[TB] FAIL load_wb: got v%b d%h w%b r%h req%b expected v1 dDEADBEEF w1 r5 req0",
               wb_valid, wb_data, wb_wreg, wb_dest, mem_req);
    end
  endtask

  // Both load and store flags set: write wins, immediate ack, no register writeback.
  task automatic test_store();
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h200, 32'h55, 4'd7);
    #1;
    checkCount++;
    if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_wdata !== 32'h55 || mem_addr !== 32'h200) begin
      errorCount++;
      $display("[TB] FAIL store_issue: got req%b we%b wd%h a%h expected req1 we1 wd00000055 a00000200",
               mem_req, mem_we, mem_wdata, mem_addr);
    end
    @(posedge clk); #1;
    driveIdle();
    mem_ack = 1'b1; mem_rdata = 32'h12345678;
    #1;
    checkCount++;
    if (mem_we !== 1'b1 || mem_wdata !== 32'h55 || stall !== 1'b0) begin
      errorCount++;
      $display("[TB] FAIL store_wait: got we%b wd%h s%b expected we1 wd00000055 s0", mem_we, mem_wdata, stall);
    end
    @(posedge clk); #1;
    mem_ack = 1'b0;
    checkCount++;
    if (wb_valid !== 1'b1 || wb_wreg !== 1'b0 || wb_data !== 32'h200 || wb_dest !== 4'd7) begin
      errorCount++;
      $display("[TB] FAIL store_wb: got v%b w%b d%h r%h expected v1 w0 d00000200 r7",
               wb_valid, wb_wreg, wb_data, wb_dest);
    end
  endtask

  // A stray ack while idle must not produce a writeback.
  task automatic test_ack_in_idle();
    mem_ack = 1'b1; mem_rdata = 32'hBADBAD00;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    checkCount++;
    if (wb_valid !== 1'b0 || mem_req !== 1'b0 || err !== 1'b0) begin
      errorCount++;
      $display("[TB] FAIL ack_idle: got v%b req%b err%b expected v0 req0 err0", wb_valid, mem_req, err);
    end
  endtask

  // Misaligned load: no request, no stall, retires with err set; err sticks.
  task automatic test_misaligned();
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h103, 32'h0, 4'd2);
    #1;
    checkCount++;
    if (mem_req !== 1'b0 || stall !== 1'b0) begin
      errorCount++;
      $display("[TB] FAIL misaligned_no_req: got req%b s%b expected 0 0", mem_req, stall);
    end
    @(posedge clk); #1;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'hAB, 32'h0, 4'd1);
    checkCount++;
    if (wb_valid !== 1'b1 || wb_wreg !== 1'b0 || err !== 1'b1 || mem_req !== 1'b0) begin
      errorCount++;
      $display("[TB] FAIL misaligned_wb: got v%b w%b err%b req%b expected v1 w0 err1 req0",
               wb_valid, wb_wreg, err, mem_req);
    end
    @(posedge clk); #1;
    driveIdle();
    checkCount++;
    if (err !== 1'b1 || wb_data !== 32'hAB || wb_jmp !== 1'b1) begin
      errorCount++;
      $display("[TB] FAIL err_sticky: got err%b d%h j%b expected err1 d000000AB j1", err, wb_data, wb_jmp);
    end
  endtask

  // Reset in the second WAIT cycle abandons the access; a late ack does nothing.
  task automatic test_reset_in_wait();
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h300, 32'h0, 4'd6);
    @(posedge clk); #1;
    driveIdle();
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    checkCount++;
    if ({mem_req, mem_we, stall, err, wb_valid, wb_wreg, wb_jmp} !== 7'b0 ||
        mem_addr !== 32'h0 || mem_wdata !== 32'h0 || wb_data !== 32'h0 || wb_dest !== 4'h0) begin
      errorCount++;
      $display("[TB] FAIL reset_in_wait: got flags %b a%h wd%h d%h r%h expected all 0",
               {mem_req, mem_we, stall, err, wb_valid, wb_wreg, wb_jmp}, mem_addr, mem_wdata, wb_data, wb_dest);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    mem_ack = 1'b1; mem_rdata = 32'hCAFE;
    #1;
    checkCount++;
    if (mem_req !== 1'b0 || stall !== 1'b0) begin
      errorCount++;
      $display("[TB] FAIL late_ack_idle: got req%b s%b expected 0 0", mem_req, stall);
    end
    @(posedge clk); #1;
    mem_ack = 1'b0;
    checkCount++;
    if (wb_valid !== 1'b0 || wb_data !== 32'h0) begin
      errorCount++;
      $display("[TB] FAIL late_ack_wb: got v%b d%h expected v0 d00000000", wb_valid, wb_data);
    end
  endtask

  // Load that is never acknowledged.
  task automatic test_timeout();
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h400, 32'h0, 4'd8);
    @(posedge clk); #1;
    driveIdle();
`ifdef MEM_STAGE_TIMEOUT_EN
    for (int i = 2; i <= 15; i++) begin
      @(posedge clk); #1;
      checkCount++;
      if (mem_req !== 1'b1 || stall !== 1'b1) begin
        errorCount++;
        $display("[TB] FAIL timeout_wait%0d: got req%b s%b expected 1 1", i, mem_req, stall);
      end
    end
    @(posedge clk); #1;
    checkCount++;
    if (mem_req !== 1'b0 || wb_valid !== 1'b1 || wb_wreg !== 1'b0 || err !== 1'b1) begin
      errorCount++;
      $display("[TB] FAIL timeout_expire: got req%b v%b w%b err%b expected req0 v1 w0 err1",
               mem_req, wb_valid, wb_wreg, err);
    end
`else
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk); #1;
      checkCount++;
      if (mem_req !== 1'b1 || mem_addr !== 32'h400 || err !== 1'b0) begin
        errorCount++;
        $display("[TB] FAIL no_timeout_wait%0d: got req%b a%h err%b expected req1 a00000400 err0",
                 i, mem_req, mem_addr, err);
      end
    end
    mem_ack = 1'b1; mem_rdata = 32'h600D;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    checkCount++;
    if (wb_valid !== 1'b1 || wb_data !== 32'h600D || wb_dest !== 4'd8 || mem_req !== 1'b0) begin
      errorCount++;
      $display("[TB] FAIL no_timeout_ack: got v%b d%h r%h req%b expected v1 d0000600D r8 req0",
               wb_valid, wb_data, wb_dest, mem_req);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_store();
    test_ack_in_idle();
    test_misaligned();
    test_reset_in_wait();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
